// File: rtl/vi_pkg.sv
// Shared types, priority-mode constants and vector address helper for the vectored interrupt controller.
package vi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Widest address / index the helper handles; callers cast down to their own widths.
  localparam int unsigned VEC_MAX_W = 64;
  localparam int unsigned IDX_MAX_W = 8;

  // Replace the low idx_w bits of base with the channel index.
  function automatic logic [VEC_MAX_W-1:0] vec_addr(input logic [VEC_MAX_W-1:0] base,
                                                    input logic [IDX_MAX_W-1:0] idx,
                                                    input int unsigned          idx_w);
    logic [VEC_MAX_W-1:0] mask;
    mask = (VEC_MAX_W'(1) << idx_w) - VEC_MAX_W'(1);
    return (base & ~mask) | (VEC_MAX_W'(idx) & mask);
  endfunction

endpackage

// File: rtl/vectored_int_ctrl_if.sv
// Peripheral/CPU side bundle of the vectored interrupt controller.
interface vectored_int_ctrl_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 32
);
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] int_en;
  logic              int_ack;
  logic              int_eoi;
  logic              irq;
  logic              int_vld;
  logic [ADDR_W-1:0] int_addr;
  logic [NUM_CH-1:0] pending;

  modport master (
    output done, int_en, int_ack, int_eoi,
    input  irq, int_vld, int_addr, pending
  );

  modport slave (
    input  done, int_en, int_ack, int_eoi,
    output irq, int_vld, int_addr, pending
  );
endinterface

// File: rtl/vi_prio_sel.sv
// Priority encoder over eligible channels: highest index (mode=0) or rotating start (mode=1).
module vi_prio_sel #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IDX_W-1:0]  start,
  input  logic              mode,
  output logic              any,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] pos;

  // Later loop iterations overwrite earlier hits, so the last hit is the winner.
  always_comb begin
    any = |eligible;
    idx = '0;
    pos = '0;
    if (mode) begin
      // Walk offsets from farthest to nearest so the channel closest to start wins.
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        pos = IDX_W'((32'(start) + NUM_CH - 1 - j) % NUM_CH);
        if (eligible[pos]) idx = pos;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (eligible[IDX_W'(i)]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Clocked vectored interrupt controller: edge capture, pending/mask, arbitration, ack/eoi handshake.
module vectored_int_ctrl
  import vi_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(32'hFFFF_FFFC),
  parameter int unsigned       PRIO_MODE = PRIO_FIXED
) (
  input logic               clk,
  input logic               rst_n,
  vectored_int_ctrl_if.slave bus
);

  localparam int unsigned      IDX_W   = $clog2(NUM_CH);
  localparam logic             MODE_RR = (PRIO_MODE == PRIO_RR);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] rise, clr, eligible;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic [IDX_W-1:0]  sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0]  start, win_idx;
  logic              win_any;
  logic              irq_q, irq_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  function automatic logic [ADDR_W-1:0] chan_addr(input logic [IDX_W-1:0] idx);
    return ADDR_W'(vec_addr(VEC_MAX_W'(VEC_BASE), IDX_MAX_W'(idx), IDX_W));
  endfunction

  // Rising-edge detect, eligibility mask and round-robin search start.
  always_comb begin
    done_d   = bus.done;
    rise     = bus.done & ~done_q;
    eligible = pending_q & bus.int_en;
    start    = (last_idx_q == LAST_CH) ? '0 : last_idx_q + IDX_W'(1);
  end

  vi_prio_sel #(
    .NUM_CH (NUM_CH)
  ) u_prio_sel (
    .eligible (eligible),
    .start    (start),
    .mode     (MODE_RR),
    .any      (win_any),
    .idx      (win_idx)
  );

  // Next state, grant bookkeeping and registered output values.
  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    last_idx_d = last_idx_q;
    clr        = '0;
    unique case (state_q)
      IDLE: begin
        if (win_any) state_d = REQ;
      end
      REQ: begin
        if (!win_any) begin
          state_d = IDLE;
        end else if (bus.int_ack) begin
          sel_idx_d  = win_idx;
          last_idx_d = win_idx;
          clr        = NUM_CH'(1) << win_idx;
          state_d    = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.int_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new rise wins over a same-cycle clear so the event is not lost.
    pending_d = (pending_q & ~clr) | rise;
    irq_d     = (state_d == REQ);
    vld_d     = (state_d == SERVICE);
    addr_d    = chan_addr(sel_idx_d);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      done_q     <= '0;
      pending_q  <= '0;
      last_idx_q <= LAST_CH;
      sel_idx_q  <= '0;
      irq_q      <= 1'b0;
      vld_q      <= 1'b0;
      addr_q     <= chan_addr('0);
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      last_idx_q <= last_idx_d;
      sel_idx_q  <= sel_idx_d;
      irq_q      <= irq_d;
      vld_q      <= vld_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.irq      = irq_q;
  assign bus.int_vld  = vld_q;
  assign bus.int_addr = addr_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Bench for vectored_int_ctrl: fixed and round-robin instances share one stimulus stream.
module tb_vectored_int_ctrl;

  localparam int N = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] done_r = 4'h0;
  logic [3:0] en_r   = 4'hF;
  logic       ack_r  = 1'b0;
  logic       eoi_r  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vectored_int_ctrl_if #(.NUM_CH(4), .ADDR_W(32)) bus_f ();
  vectored_int_ctrl_if #(.NUM_CH(4), .ADDR_W(32)) bus_r ();

  assign bus_f.done    = done_r;
  assign bus_f.int_en  = en_r;
  assign bus_f.int_ack = ack_r;
  assign bus_f.int_eoi = eoi_r;
  assign bus_r.done    = done_r;
  assign bus_r.int_en  = en_r;
  assign bus_r.int_ack = ack_r;
  assign bus_r.int_eoi = eoi_r;

  vectored_int_ctrl #(.NUM_CH(4), .ADDR_W(32), .VEC_BASE(32'hFFFF_FFFC), .PRIO_MODE(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f)
  );
  vectored_int_ctrl #(.NUM_CH(4), .ADDR_W(32), .VEC_BASE(32'hFFFF_FFFC), .PRIO_MODE(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .bus(bus_r)
  );

  // Reference model: index 0 = fixed priority, index 1 = round-robin.
  // phase: 0 = nothing outstanding, 1 = irq raised and awaiting ack, 2 = channel in service.
  int          m_pend  [2];
  int          m_prev  [2];
  int          m_last  [2];
  int          m_phase [2];
  logic [31:0] exp_f[$];
  logic [31:0] exp_r[$];
  logic [31:0] cur_addr [2];
  bit          prev_vld [2];

  function automatic logic [31:0] vec_of(input int ch);
    logic [29:0] hi;
    hi = 30'h3FFF_FFFF;
    return {hi, 2'(ch)};
  endfunction

  function automatic int pick(input int elig, input int last, input bit rr);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (((elig >> i) & 1) != 0) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (((elig >> c) & 1) != 0) return c;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input int m);
    int elig, rise, nph, w;
    if (!rst_n) begin
      m_pend[m] = 0; m_prev[m] = 0; m_last[m] = N - 1; m_phase[m] = 0;
      return;
    end
    elig = m_pend[m] & int'(en_r);
    rise = int'(done_r) & ~m_prev[m];
    nph  = m_phase[m];
    if (m_phase[m] == 0) begin
      if (elig != 0) nph = 1;
    end else if (m_phase[m] == 1) begin
      if (elig == 0) nph = 0;
      else if (ack_r) begin
        w = pick(elig, m_last[m], m == 1);
        m_pend[m] = m_pend[m] & ~(1 << w);
        m_last[m] = w;
        if (m == 0) exp_f.push_back(vec_of(w));
        else        exp_r.push_back(vec_of(w));
        nph = 2;
      end
    end else if (eoi_r) begin
      nph = 0;
    end
    m_pend[m]  = (m_pend[m] | rise) & 32'hF;
    m_prev[m]  = int'(done_r);
    m_phase[m] = nph;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", name, m, $time, act, exp);
    end
  endtask

  // Monitor: per-cycle status checks, and the scoreboard pop whenever a vector is presented.
  task automatic check_inst(input int m, input logic irq, input logic vld,
                            input logic [3:0] pend, input logic [31:0] addr);
    cmp("irq", m, 32'(irq), 32'(m_phase[m] == 1));
    cmp("int_vld", m, 32'(vld), 32'(m_phase[m] == 2));
    cmp("pending", m, 32'(pend), 32'(m_pend[m]));
    if (vld && !prev_vld[m]) begin
      if ((m == 0 && exp_f.size() == 0) || (m == 1 && exp_r.size() == 0)) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_vector inst=%0d t=%0t actual=%h required=none", m, $time, addr);
      end else begin
        cur_addr[m] = (m == 0) ? exp_f.pop_front() : exp_r.pop_front();
      end
    end
    if (vld) cmp("int_addr", m, addr, cur_addr[m]);
    prev_vld[m] = vld;
  endtask

  always @(negedge clk) begin
    check_inst(0, bus_f.irq, bus_f.int_vld, bus_f.pending, bus_f.int_addr);
    check_inst(1, bus_r.irq, bus_r.int_vld, bus_r.pending, bus_r.int_addr);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] mask);
    done_r = mask; @(negedge clk); done_r = 4'h0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; idle(n); rst_n = 1'b1;
  endtask

  task automatic wait_irq();
    int t;
    t = 0;
    while (!(bus_f.irq || bus_r.irq) && t < 30) begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (t >= 30) begin
      n_fail++;
      $display("FAIL wait_irq timeout t=%0t actual=irq_low required=irq_high", $time);
    end
  endtask

  task automatic ack1();
    ack_r = 1'b1; @(negedge clk); ack_r = 1'b0;
  endtask

  task automatic eoi1();
    eoi_r = 1'b1; @(negedge clk); eoi_r = 1'b0;
  endtask

  task automatic serve();
    wait_irq(); ack1(); idle(2); eoi1(); idle(1);
  endtask

  initial begin
    // Reset with idle inputs.
    idle(5);
    cmp("rst_addr", 0, bus_f.int_addr, 32'hFFFF_FFFC);
    cmp("rst_addr", 1, bus_r.int_addr, 32'hFFFF_FFFC);
    cmp("rst_pending", 0, 32'(bus_f.pending), 32'h0);
    cmp("rst_irq", 1, 32'(bus_r.irq), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Single channel, then simultaneous channels 3 and 0.
    pulse(4'b0001); serve();
    pulse(4'b1001); serve(); serve();

    // Round-robin rotation from reset.
    do_reset(2);
    repeat (5) begin pulse(4'hF); serve(); end

    // Masked pending bit held, then unmasked.
    do_reset(2);
    en_r = 4'b1011; pulse(4'b0100); idle(10);
    cmp("masked_irq", 0, 32'(bus_f.irq), 32'h0);
    cmp("masked_pending", 1, 32'(bus_r.pending), 32'h4);
    en_r = 4'hF; serve();

    // Re-pulse of the in-service channel.
    do_reset(2);
    pulse(4'b0010); wait_irq(); ack1(); pulse(4'b0010); eoi1(); serve();

    // Reset in the middle of service.
    pulse(4'b0001); wait_irq(); ack1(); idle(1);
    do_reset(1);
    cmp("midrst_vld", 0, 32'(bus_f.int_vld), 32'h0);
    cmp("midrst_pending", 1, 32'(bus_r.pending), 32'h0);

    // Ack held with nothing pending.
    idle(3); ack_r = 1'b1; idle(5); ack_r = 1'b0; idle(2);

    // Randomised traffic including masking, stray ack/eoi and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) done_r = 4'($urandom);
      if ($urandom_range(0, 9) == 0) en_r = 4'($urandom);
      else if ($urandom_range(0, 19) == 0) en_r = 4'hF;
      ack_r = ($urandom_range(0, 2) == 0);
      eoi_r = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    done_r = 4'h0; ack_r = 1'b0; eoi_r = 1'b0; rst_n = 1'b1;
    idle(3);

    cmp("sb_leftover", 0, 32'(exp_f.size()), 32'h0);
    cmp("sb_leftover", 1, 32'(exp_r.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
